// File: rtl/writeback_scoreboard_if.sv
// writeback_scoreboard_if
//   Bundles the issue port, the register-file read/write ports and the two
//   write-back producers (ALU and load return) seen by writeback_scoreboard.
//   master: the surrounding pipeline / register file; slave: the scoreboard.
interface writeback_scoreboard_if;
  // Issue stage
  logic        issue_valid;
  logic        issue_load;
  logic [4:0]  issue_rd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        stall;
  // ALU producer
  logic        alu_valid;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        alu_ready;
  // Load producer
  logic        ld_valid;
  logic [4:0]  ld_wa;
  logic [31:0] ld_wd;
  // Register file write port and scoreboard view
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pending;

  modport master (
    output issue_valid, issue_load, issue_rd, ra1, ra2, rf_rd1, rf_rd2,
    output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
    input  rd1, rd2, stall, alu_ready, we, wa, wd, pending
  );

  modport slave (
    input  issue_valid, issue_load, issue_rd, ra1, ra2, rf_rd1, rf_rd2,
    input  alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
    output rd1, rd2, stall, alu_ready, we, wa, wd, pending
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard
//   Owns the register file write port. Load returns always win the port; ALU
//   results that lose arbitration wait in an in-order skid buffer of DEPTH
//   entries. A per-register pending scoreboard tracks loads in flight, and
//   issue is stalled on RAW/WAW hazards against them.
//   Optional feature: define WB_BYPASS_EN to forward in-flight write data to
//   rd1/rd2 instead of stalling on ALU write hazards.
module writeback_scoreboard #(
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  writeback_scoreboard_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    count_q, count_d;
  logic [4:0]       buf_wa_q [DEPTH];
  logic [4:0]       buf_wa_d [DEPTH];
  logic [31:0]      buf_wd_q [DEPTH];
  logic [31:0]      buf_wd_d [DEPTH];
  logic [DEPTH-1:0] buf_vld;
  logic [31:0]      pending_q, pending_d;

  logic             sel_valid;
  logic [4:0]       sel_wa;
  logic [31:0]      sel_wd;
  logic             pop, direct, push;
  logic             alu_ready;
  logic             we_int;
  logic [4:0]       wa_int;
  logic [31:0]      wd_int;
  logic [31:0]      rd1_int, rd2_int;
  logic             hz;
  logic             stall_int;
  logic             issue_set;

  assign alu_ready = (count_q != CW'(DEPTH));

  // Occupancy mask: slot i holds a live entry when i < count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      buf_vld[i] = (CW'(i) < count_q);
    end
  end

  // Write-port arbitration: load return, then oldest buffered ALU result, then direct ALU
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    sel_valid = 1'b0;
    sel_wa    = 5'd0;
    sel_wd    = 32'd0;
    pop       = 1'b0;
    direct    = 1'b0;
    if (bus.ld_valid) begin
      sel_valid = 1'b1;
      sel_wa    = bus.ld_wa;
      sel_wd    = bus.ld_wd;
    end else if (count_q != '0) begin
      sel_valid = 1'b1;
      sel_wa    = buf_wa_q[0];
      sel_wd    = buf_wd_q[0];
      pop       = 1'b1;
    end else if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_wa    = bus.alu_wa;
      sel_wd    = bus.alu_wd;
      direct    = 1'b1;
    end
  end

  // A losing ALU result is queued; x0 results and results offered while full are dropped
  assign push = bus.alu_valid & alu_ready & ~direct & (bus.alu_wa != 5'd0);

  // x0 writes still consume their slot but never reach the register file; nothing is written in reset
  assign we_int = rst_n & sel_valid & (sel_wa != 5'd0);
  assign wa_int = rst_n ? sel_wa : 5'd0;
  assign wd_int = rst_n ? sel_wd : 32'd0;

  // Skid-buffer next state: shift out the head on pop, append behind the survivors on push
  always_comb begin
    int push_idx;
    buf_wa_d = buf_wa_q;
    buf_wd_d = buf_wd_q;
    push_idx = int'(count_q) - int'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        buf_wa_d[i] = buf_wa_q[i+1];
        buf_wd_d[i] = buf_wd_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == push_idx) begin
          buf_wa_d[i] = bus.alu_wa;
          buf_wd_d[i] = bus.alu_wd;
        end
      end
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Scoreboard next state: clear on load return, set on accepted load issue (set wins)
  assign issue_set = bus.issue_valid & bus.issue_load & ~stall_int & (bus.issue_rd != 5'd0);

  always_comb begin
    pending_d = pending_q;
    if (bus.ld_valid) pending_d[bus.ld_wa] = 1'b0;
    if (issue_set)    pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Control state: buffer occupancy and pending bits, discarded at once by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Buffer payload storage
  // NOTE: payload slots carry no reset; they are only ever read when the occupancy count marks them live.
  always_ff @(posedge clk) begin
    buf_wa_q <= buf_wa_d;
    buf_wd_q <= buf_wd_d;
  end

`ifdef WB_BYPASS_EN
  // Operand forwarding: current write first, then newest matching buffer entry, then register file
  always_comb begin
    rd1_int = bus.rf_rd1;
    rd2_int = bus.rf_rd2;
    for (int i = 0; i < DEPTH; i++) begin
      if (buf_vld[i] && (buf_wa_q[i] == bus.ra1)) rd1_int = buf_wd_q[i];
      if (buf_vld[i] && (buf_wa_q[i] == bus.ra2)) rd2_int = buf_wd_q[i];
    end
    if (we_int && (wa_int == bus.ra1)) rd1_int = wd_int;
    if (we_int && (wa_int == bus.ra2)) rd2_int = wd_int;
  end

  assign hz = 1'b0;
`else
  assign rd1_int = bus.rf_rd1;
  assign rd2_int = bus.rf_rd2;

  // Write hazard: a nonzero source matches the register being written now or any queued ALU result
  always_comb begin
    hz = 1'b0;
    if (we_int && (bus.ra1 != 5'd0) && (bus.ra1 == wa_int)) hz = 1'b1;
    if (we_int && (bus.ra2 != 5'd0) && (bus.ra2 == wa_int)) hz = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (buf_vld[i] && (bus.ra1 != 5'd0) && (buf_wa_q[i] == bus.ra1)) hz = 1'b1;
      if (buf_vld[i] && (bus.ra2 != 5'd0) && (buf_wa_q[i] == bus.ra2)) hz = 1'b1;
    end
  end
`endif

  // Issue stall: RAW/WAW against loads in flight, write hazards, or no room for an ALU result
  assign stall_int = rst_n & bus.issue_valid &
                     ((pending_q[bus.ra1]      & (bus.ra1 != 5'd0)) |
                      (pending_q[bus.ra2]      & (bus.ra2 != 5'd0)) |
                      (pending_q[bus.issue_rd] & (bus.issue_rd != 5'd0)) |
                      hz | ~alu_ready);

  assign bus.we        = we_int;
  assign bus.wa        = wa_int;
  assign bus.wd        = wd_int;
  assign bus.rd1       = rd1_int;
  assign bus.rd2       = rd2_int;
  assign bus.stall     = stall_int;
  assign bus.alu_ready = alu_ready;
  assign bus.pending   = pending_q;
endmodule

// File: tb/tb_writeback_scoreboard.sv
// tb_writeback_scoreboard
//   Directed test of writeback_scoreboard (DEPTH=2). Expected values are
//   hand-computed; expectations that depend on WB_BYPASS_EN follow the same
//   macro so either build can be checked.
module tb_writeback_scoreboard;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] RF1 = 32'hDEAD_0001;
  localparam logic [31:0] RF2 = 32'hDEAD_0002;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  writeback_scoreboard_if bus ();

  writeback_scoreboard #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_load  = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.ra1         = 5'd0;
    bus.ra2         = 5'd0;
    bus.alu_valid   = 1'b0;
    bus.alu_wa      = 5'd0;
    bus.alu_wd      = 32'd0;
    bus.ld_valid    = 1'b0;
    bus.ld_wa       = 5'd0;
    bus.ld_wd       = 32'd0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_wa    = a;
    bus.alu_wd    = d;
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_wa    = a;
    bus.ld_wd    = d;
  endtask

  task automatic issue(input logic load, input logic [4:0] rd,
                       input logic [4:0] s1, input logic [4:0] s2);
    bus.issue_valid = 1'b1;
    bus.issue_load  = load;
    bus.issue_rd    = rd;
    bus.ra1         = s1;
    bus.ra2         = s2;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.rf_rd1 = RF1;
    bus.rf_rd2 = RF2;
    idle();

    // Reset state
    #1;
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_wa", 32'(bus.wa), 32'd0);
    check("rst_wd", bus.wd, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("rst_pending", bus.pending, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: direct ALU write, zero latency
    alu(5'd5, 32'hA5A5_0001);
    #1;
    check("t1_we", 32'(bus.we), 32'd1);
    check("t1_wa", 32'(bus.wa), 32'd5);
    check("t1_wd", bus.wd, 32'hA5A5_0001);
    check("t1_pending", bus.pending, 32'd0);
    tick();
    idle();
    #1;
    check("t1_not_buffered", 32'(bus.we), 32'd0);

    // T2: load rd=7 in flight stalls a reader of x7 until it returns
    tick();
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    #1;
    check("t2_issue_ok", 32'(bus.stall), 32'd0);
    tick();
    check("t2_pending_set", bus.pending, 32'h0000_0080);
    issue(1'b0, 5'd1, 5'd7, 5'd0);
    #1;
    check("t2_raw_stall", 32'(bus.stall), 32'd1);
    tick();
    check("t2_still_pending", bus.pending, 32'h0000_0080);
    check("t2_stall_held", 32'(bus.stall), 32'd1);
    ld(5'd7, 32'h0000_1234);
    #1;
    check("t2_ld_we", 32'(bus.we), 32'd1);
    check("t2_ld_wa", 32'(bus.wa), 32'd7);
    check("t2_ld_wd", bus.wd, 32'h0000_1234);
    check("t2_stall_on_return", 32'(bus.stall), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    #1;
    check("t2_pending_clear", bus.pending, 32'd0);
    check("t2_stall_release", 32'(bus.stall), 32'd0);
    tick();
    idle();

    // Set beats clear on the same bit; load to a non-pending register is still written
    ld(5'd9, 32'h0000_0999);
    issue(1'b1, 5'd9, 5'd0, 5'd0);
    #1;
    check("sw_we", 32'(bus.we), 32'd1);
    check("sw_wa", 32'(bus.wa), 32'd9);
    check("sw_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    check("sw_pending", bus.pending, 32'h0000_0200);
    ld(5'd9, 32'h0000_0009);
    tick();
    idle();
    check("sw_cleared", bus.pending, 32'd0);

    // T3: load wins the port, ALU result follows from the buffer
    ld(5'd3, 32'h0000_0033);
    alu(5'd4, 32'h0000_0044);
    #1;
    check("t3_ld_wa", 32'(bus.wa), 32'd3);
    check("t3_ld_wd", bus.wd, 32'h0000_0033);
    tick();
    idle();
    issue(1'b0, 5'd0, 5'd4, 5'd0);
    #1;
    check("t3_buf_we", 32'(bus.we), 32'd1);
    check("t3_buf_wa", 32'(bus.wa), 32'd4);
    check("t3_buf_wd", bus.wd, 32'h0000_0044);
    check("t3_hz_stall", 32'(bus.stall), BYP ? 32'd0 : 32'd1);
    check("t3_rd1", bus.rd1, BYP ? 32'h0000_0044 : RF1);
    tick();
    idle();
    #1;
    check("t3_drained", 32'(bus.we), 32'd0);

    // T4: three load cycles back up ALU results 8,9,10; DEPTH=2 fills after two
    ld(5'd11, 32'h0000_00B0);
    alu(5'd8, 32'h0000_0088);
    #1;
    check("t4_a_wa", 32'(bus.wa), 32'd11);
    tick();
    ld(5'd12, 32'h0000_00B1);
    alu(5'd9, 32'h0000_0099);
    issue(1'b0, 5'd0, 5'd0, 5'd8);
    #1;
    check("t4_b_ready", 32'(bus.alu_ready), 32'd1);
    check("t4_b_buf_hz", 32'(bus.stall), BYP ? 32'd0 : 32'd1);
    check("t4_b_rd2", bus.rd2, BYP ? 32'h0000_0088 : RF2);
    tick();
    idle();
    ld(5'd13, 32'h0000_00B2);
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("t4_c_full", 32'(bus.alu_ready), 32'd0);
    check("t4_c_full_stall", 32'(bus.stall), 32'd1);
    check("t4_c_wa", 32'(bus.wa), 32'd13);
    tick();
    idle();
    #1;
    check("t4_d_wa", 32'(bus.wa), 32'd8);
    check("t4_d_wd", bus.wd, 32'h0000_0088);
    check("t4_d_still_full", 32'(bus.alu_ready), 32'd0);
    tick();
    check("t4_e_ready", 32'(bus.alu_ready), 32'd1);
    alu(5'd10, 32'h0000_00AA);
    #1;
    check("t4_e_wa", 32'(bus.wa), 32'd9);
    check("t4_e_wd", bus.wd, 32'h0000_0099);
    tick();
    idle();
    #1;
    check("t4_f_we", 32'(bus.we), 32'd1);
    check("t4_f_wa", 32'(bus.wa), 32'd10);
    check("t4_f_wd", bus.wd, 32'h0000_00AA);
    tick();
    check("t4_empty", 32'(bus.we), 32'd0);

    // T5: x0 handling
    alu(5'd0, 32'h0000_0055);
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    check("t5_we", 32'(bus.we), 32'd0);
    check("t5_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    #1;
    check("t5_pending", bus.pending, 32'd0);
    check("t5_not_buffered", 32'(bus.we), 32'd0);
    ld(5'd0, 32'h0000_0077);
    alu(5'd14, 32'h0000_00EE);
    #1;
    check("t5_ld_x0_we", 32'(bus.we), 32'd0);
    tick();
    idle();
    #1;
    check("t5_after_x0_wa", 32'(bus.wa), 32'd14);
    check("t5_after_x0_wd", bus.wd, 32'h0000_00EE);
    tick();

    // T6: reset mid-operation with two buffered entries and pending[7]
    ld(5'd20, 32'h0000_0020);
    alu(5'd21, 32'h0000_0021);
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    idle();
    ld(5'd22, 32'h0000_0022);
    alu(5'd23, 32'h0000_0023);
    tick();
    idle();
    #1;
    check("t6_pre_full", 32'(bus.alu_ready), 32'd0);
    check("t6_pre_pending", bus.pending, 32'h0000_0080);
    check("t6_pre_we", 32'(bus.we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_we", 32'(bus.we), 32'd0);
    check("t6_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("t6_pending", bus.pending, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_discarded", 32'(bus.we), 32'd0);

    // T7: ALU write to x6 while issue reads x6
    alu(5'd6, 32'h0000_0066);
    issue(1'b0, 5'd1, 5'd0, 5'd6);
    #1;
    check("t7_we", 32'(bus.we), 32'd1);
    check("t7_stall", 32'(bus.stall), BYP ? 32'd0 : 32'd1);
    check("t7_rd2", bus.rd2, BYP ? 32'h0000_0066 : RF2);
    check("t7_rd1", bus.rd1, RF1);
    tick();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
